// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates EX redirects, multi-cycle holds and load-use
// hazards, and drives hold/flush to the PC, if_id and id_ex registers.
// Also keeps saturating stall and redirect performance counters.
module pipe_ctrl #(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_ex_i,
  input  logic             hold_bus_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_is_load_i,
  input  logic             ex_reg_wen_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {StRun, StHold, StRedirect} state_e;

  state_e           state_q;
  logic             pend_vld_q;
  logic [31:0]      pend_addr_q;
  logic [2:0]       redir_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic hold;
  logic lu_hazard;
  logic redirect_issue;

  assign hold = hold_ex_i | hold_bus_i;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu_hazard = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                     ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

  // A deferred jump is replayed as soon as the hold drops; it wins over a new one.
  assign redirect_issue = ~hold & (pend_vld_q | jump_en_i);

  // Control outputs: hold > redirect issue > redirect flush tail > load-use bubble.
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_hold_o  = 1'b0;
    id_ex_flush_o = 1'b0;
    if (!rst) begin
      if (hold) begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
        id_ex_hold_o = 1'b1;
      end else if (redirect_issue) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = pend_vld_q ? pend_addr_q : jump_addr_i;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (state_q == StRedirect) begin
        // Instruction ROM still returns wrong-path words; keep if_id empty.
        if_id_flush_o = 1'b1;
      end else if (lu_hazard) begin
        // One bubble: freeze fetch/decode, insert NOP into EX.
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  // Sequencer state, deferred-jump capture and redirect flush countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= 32'd0;
      redir_cnt_q <= 3'd0;
    end else if (hold) begin
      // First jump seen during a hold wins; later ones are dropped.
      if (jump_en_i && !pend_vld_q) begin
        pend_vld_q  <= 1'b1;
        pend_addr_q <= jump_addr_i;
      end
      if (state_q != StRedirect) begin
        state_q <= StHold;
      end
    end else if (redirect_issue) begin
      pend_vld_q <= 1'b0;
      if (REDIRECT_CYCLES > 1) begin
        redir_cnt_q <= 3'(REDIRECT_CYCLES - 1);
        state_q     <= StRedirect;
      end else begin
        state_q <= StRun;
      end
    end else if (state_q == StRedirect) begin
      if (redir_cnt_q <= 3'd1) begin
        state_q <= StRun;
      end else begin
        redir_cnt_q <= redir_cnt_q - 3'd1;
      end
    end else begin
      state_q <= StRun;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (jump_en_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
